// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C register-transfer sequencer.
// Holds the byte offsets of the I2C master register file, CMD/STATUS bit
// positions, response error codes, the sequencer state enum, and helpers
// that turn (direction, step) into the TX byte and CMD byte for a step.
package i2c_seq_pkg;

  // Register byte offsets in the I2C master peripheral
  localparam logic [7:0] REG_PRE    = 8'h00;
  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_RX     = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;
  localparam logic [7:0] REG_TX     = 8'h10;
  localparam logic [7:0] REG_CMD    = 8'h14;

  // CMD register bits
  localparam int CMD_STA  = 7;
  localparam int CMD_STO  = 6;
  localparam int CMD_RD   = 5;
  localparam int CMD_WR   = 4;
  localparam int CMD_ACK  = 3;
  localparam int CMD_IACK = 0;

  // STATUS register bits
  localparam int ST_RXACK = 7;
  localparam int ST_AL    = 5;
  localparam int ST_TIP   = 1;
  localparam int ST_IF    = 0;

  localparam logic [7:0] CTRL_ENABLE   = 8'h80;  // core on, interrupt off
  localparam logic [7:0] CMD_IACK_ONLY = 8'h01;
  localparam logic [7:0] CMD_STOP_IACK = 8'h41;

  // Response error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_AL      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    INIT_PRE, INIT_CTRL, IDLE, WR_TX, WR_CMD, POLL, CHECK,
    RD_RX, FINISH, ABORT, ABORT_NOSTOP, RESP
  } seq_state_t;

  // Base CMD byte of a step, before IACK is merged in
  function automatic logic [7:0] step_cmd(input logic rnw, input logic [1:0] step);
    case (step)
      2'd0:    step_cmd = 8'h90;                 // STA+WR
      2'd1:    step_cmd = 8'h10;                 // WR
      2'd2:    step_cmd = rnw ? 8'h90 : 8'h50;   // repeated STA+WR / WR+STO
      default: step_cmd = 8'h68;                 // RD+ACK(nack)+STO
    endcase
  endfunction

  // TX byte of a step (step 3 of a read has no TX write)
  function automatic logic [7:0] step_tx(input logic rnw, input logic [1:0] step,
                                         input logic [6:0] dev, input logic [7:0] reg_addr,
                                         input logic [7:0] wdata);
    case (step)
      2'd0:    step_tx = {dev, 1'b0};
      2'd1:    step_tx = reg_addr;
      2'd2:    step_tx = rnw ? {dev, 1'b1} : wdata;
      default: step_tx = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_reg_xfer_seq_apb.sv
// Single-access APB master engine.
// A start pulse (while idle) captures addr/wdata/write and runs one access:
// SETUP for one cycle, ACCESS until pready, then one idle cycle in which
// done pulses and rdata holds the sampled read data.
// Ports: clk, rst (async, active-high), start, addr, wdata, write -> done,
// rdata; APB side paddr, pwdata, pwrite, psel, penable, prdata, pready.
module apb_master_port #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          write,
  output logic          done,
  output logic [31:0]   rdata,
  output logic [AW-1:0] paddr,
  output logic [31:0]   pwdata,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic [31:0]   prdata,
  input  logic          pready
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      rdata   <= 32'h0;
      paddr   <= '0;
      pwdata  <= 32'h0;
      pwrite  <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!psel) begin
        if (start) begin
          psel   <= 1'b1;
          paddr  <= addr;
          pwdata <= wdata;
          pwrite <= write;
        end
      end else if (!penable) begin
        penable <= 1'b1;
      end else if (pready) begin
        psel    <= 1'b0;
        penable <= 1'b0;
        done    <= 1'b1;
        if (!pwrite) rdata <= prdata;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_xfer_seq.sv
// Autonomous APB master that drives an I2C master peripheral's register
// file to perform one register write or register read on an I2C device.
// Request side: req_valid/req_ready handshake (accepted when both are high,
// req_ready only in IDLE), req_rnw, req_dev, req_reg, req_wdata.
// Response side: rsp_valid one-cycle pulse with rsp_rdata and rsp_err.
// APB side: PADDR, PWDATA, PWRITE, PSEL, PENABLE, PRDATA, PREADY.
// Each access-issuing state owns exactly one APB access; 'pend' marks that
// the state's access is in flight so it is launched only once.
module i2c_reg_xfer_seq
  import i2c_seq_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [15:0] PRESCALE       = 16'd99,
  parameter int          POLL_MAX       = 1023
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rnw,
  input  logic [6:0]                req_dev,
  input  logic [7:0]                req_reg,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  output logic [7:0]                rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY
);

  localparam int PCW = $clog2(POLL_MAX + 1);

  seq_state_t state;
  logic       pend, start, done;
  logic [31:0] rdata;
  logic       acc_state, acc_write;
  logic [7:0] acc_off;
  logic [31:0] acc_wdata;
  logic [APB_ADDR_WIDTH-1:0] acc_addr;

  logic       rnw;
  logic [6:0] dev;
  logic [7:0] reg_addr, wdata, rd_byte;
  logic [1:0] step, err;
  logic       st_al, st_rxack, aborting;
  logic [PCW-1:0] poll_cnt;

  logic unused_rdata_hi;
  assign unused_rdata_hi = ^rdata[31:8];

  // Access owned by the current state
  always_comb begin
    acc_state = 1'b1;
    acc_off   = REG_STATUS;
    acc_wdata = 32'h0;
    acc_write = 1'b0;
    case (state)
      INIT_PRE:  begin acc_off = REG_PRE;  acc_wdata = {16'h0, PRESCALE};    acc_write = 1'b1; end
      INIT_CTRL: begin acc_off = REG_CTRL; acc_wdata = {24'h0, CTRL_ENABLE}; acc_write = 1'b1; end
      WR_TX: begin
        acc_off   = REG_TX;
        acc_wdata = {24'h0, step_tx(rnw, step, dev, reg_addr, wdata)};
        acc_write = 1'b1;
      end
      WR_CMD: begin
        // Every CMD after the first of a request also clears the previous IF
        acc_off   = REG_CMD;
        acc_wdata = {24'h0, step_cmd(rnw, step) | {7'h0, (step != 2'd0)}};
        acc_write = 1'b1;
      end
      POLL:  acc_off = REG_STATUS;
      RD_RX: acc_off = REG_RX;
      FINISH, ABORT_NOSTOP: begin acc_off = REG_CMD; acc_wdata = {24'h0, CMD_IACK_ONLY}; acc_write = 1'b1; end
      ABORT:                begin acc_off = REG_CMD; acc_wdata = {24'h0, CMD_STOP_IACK}; acc_write = 1'b1; end
      default: acc_state = 1'b0;
    endcase
  end

  assign acc_addr = APB_ADDR_WIDTH'(acc_off);

  apb_master_port #(.AW(APB_ADDR_WIDTH)) u_apb (
    .clk(HCLK), .rst(HRESET), .start(start), .addr(acc_addr), .wdata(acc_wdata),
    .write(acc_write), .done(done), .rdata(rdata), .paddr(PADDR), .pwdata(PWDATA),
    .pwrite(PWRITE), .psel(PSEL), .penable(PENABLE), .prdata(PRDATA), .pready(PREADY)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= INIT_PRE;
      pend      <= 1'b0;
      start     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h0;
      rsp_err   <= ERR_OK;
      rnw       <= 1'b0;
      dev       <= 7'h0;
      reg_addr  <= 8'h0;
      wdata     <= 8'h0;
      rd_byte   <= 8'h0;
      step      <= 2'd0;
      err       <= ERR_OK;
      st_al     <= 1'b0;
      st_rxack  <= 1'b0;
      aborting  <= 1'b0;
      poll_cnt  <= '0;
    end else begin
      start     <= 1'b0;
      rsp_valid <= 1'b0;
      if (acc_state && !pend) begin
        start <= 1'b1;
        pend  <= 1'b1;
      end
      if (done) pend <= 1'b0;

      case (state)
        INIT_PRE:  if (done) state <= INIT_CTRL;
        INIT_CTRL: if (done) begin state <= IDLE; req_ready <= 1'b1; end
        IDLE: if (req_valid && req_ready) begin
          rnw       <= req_rnw;
          dev       <= req_dev;
          reg_addr  <= req_reg;
          wdata     <= req_wdata;
          step      <= 2'd0;
          err       <= ERR_OK;
          rd_byte   <= 8'h0;
          aborting  <= 1'b0;
          req_ready <= 1'b0;
          state     <= WR_TX;
        end
        WR_TX:  if (done) state <= WR_CMD;
        WR_CMD: if (done) begin poll_cnt <= '0; state <= POLL; end
        POLL: if (done) begin
          // The post-STOP poll of an abort reuses this state; it never
          // overrides the error already recorded.
          if (rdata[ST_IF]) begin
            st_al    <= rdata[ST_AL];
            st_rxack <= rdata[ST_RXACK];
            state    <= aborting ? ABORT_NOSTOP : CHECK;
          end else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
            if (!aborting) err <= ERR_TIMEOUT;
            state <= aborting ? ABORT_NOSTOP : ABORT;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        CHECK: begin
          // Read step 3 RXACK is our own NACK, so it is not an error
          if (st_al) begin
            err   <= ERR_AL;
            state <= ABORT_NOSTOP;
          end else if (step != 2'd3 && st_rxack) begin
            err   <= ERR_NACK;
            state <= ABORT;
          end else if (step == (rnw ? 2'd3 : 2'd2)) begin
            state <= rnw ? RD_RX : FINISH;
          end else begin
            step  <= step + 2'd1;
            state <= (rnw && step == 2'd2) ? WR_CMD : WR_TX;
          end
        end
        RD_RX: if (done) begin rd_byte <= rdata[7:0]; state <= FINISH; end
        FINISH, ABORT_NOSTOP: if (done) state <= RESP;
        ABORT: if (done) begin aborting <= 1'b1; poll_cnt <= '0; state <= POLL; end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (rnw && err == ERR_OK) ? rd_byte : 8'h0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT_PRE;
      endcase
    end
  end

endmodule

// File: doc/i2c_reg_xfer_seq.md
Name: i2c_reg_xfer_seq

Overview:
- Autonomous APB master that sits directly upstream of the APB I2C master peripheral and drives its register file.
- Turns one request (7-bit device address, 8-bit register address, optional write byte) into the full I2C byte sequence:
  - write: START+addrW, reg, data+STOP
  - read: START+addrW, reg, repeated START+addrR, read+NACK+STOP
- Returns the read byte and a status code, so on-chip controllers can access I2C sensors without CPU involvement.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR.
- PRESCALE, 16'd99, value written to PRE register during init.
- POLL_MAX, 1023, maximum STATUS polls per byte before timeout.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_rnw  in  1  1 = read, 0 = write.
- req_dev  in  7  I2C device address.
- req_reg  in  8  register address byte.
- req_wdata  in  8  write data byte.
- rsp_valid  out  1  one-cycle pulse; result valid.
- rsp_rdata  out  8  read byte; 0 for writes and on error.
- rsp_err  out  2  0 ok, 1 NACK, 2 arbitration lost, 3 timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB write.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA). The FSM resets to INIT_PRE.
- Slave register map, byte offsets:
  - PRE 0x00, CTRL 0x04, RX 0x08, STATUS 0x0C, TX 0x10, CMD 0x14.
  - CMD bits: STA 7, STO 6, RD 5, WR 4, ACK 3, IACK 0.
  - STATUS bits: RXACK 7, AL 5, TIP 1, IF 0.
- APB access:
  - Every access is SETUP (PSEL=1, PENABLE=0) for one cycle, then ACCESS (PENABLE=1) held until PREADY=1.
  - PRDATA is sampled on the ACCESS cycle with PREADY=1.
  - PSEL deasserts the next cycle; there are no back-to-back accesses without an idle cycle.
  - Minimum 3 cycles per access.
- Init: INIT_PRE writes PRE=PRESCALE, then INIT_CTRL writes CTRL=0x80 (core enable, interrupt disabled), then IDLE. Init runs once after each reset.
- IDLE: req_ready=1. A request is accepted on req_valid&req_ready, all fields are latched, and step=0.
- Byte step table, each step being TX write then CMD write:
  - write: s0 TX={dev,0} CMD=0x90; s1 TX=reg CMD=0x10; s2 TX=wdata CMD=0x50.
  - read: s0 TX={dev,0} CMD=0x90; s1 TX=reg CMD=0x10; s2 TX={dev,1} CMD=0x90; s3 CMD=0x68 (RD+ACK(nack)+STO, no TX write).
  - Every CMD write after the first of a request ORs in IACK (bit0) to clear the previous IF.
- POLL: read STATUS repeatedly; poll counter resets per byte.
  - IF=1 goes to CHECK.
  - Counter reaching POLL_MAX with IF=0 sets err=3 and goes to ABORT.
- CHECK, in priority order:
  - AL=1 sets err=2 and goes to ABORT_NOSTOP.
  - Else, on a write-direction step (s0..s2), RXACK=1 sets err=1 and goes to ABORT.
  - Else, if the step is last (write s2, read s3), go to FINISH; otherwise step+1 and continue.
  - The read s3 RXACK is not checked; it is the master's own NACK.
- FINISH:
  - Read: read RX into rsp_rdata.
  - Both directions: write CMD=0x01 (IACK), then RESP.
- ABORT: write CMD=0x41 (STO+IACK), poll IF (bounded by POLL_MAX, no further error override), write CMD=0x01, then RESP.
- ABORT_NOSTOP: write CMD=0x01, then RESP.
- RESP: rsp_valid=1 for one cycle with rsp_err and rsp_rdata (0 unless read ok), then IDLE.
- Error precedence: the first error detected is kept. There is no retry.
- PREADY stall: the FSM holds the ACCESS phase indefinitely; timeout covers only STATUS polls.
- req_valid outside IDLE is ignored and not queued.

Decomposition:
- Package i2c_seq_pkg:
  - register offset constants;
  - CMD/STATUS bit constants;
  - rsp_err codes;
  - FSM state enum (INIT_PRE, INIT_CTRL, IDLE, WR_TX, WR_CMD, POLL, CHECK, RD_RX, FINISH, ABORT, ABORT_NOSTOP, RESP).
- Sub-module apb_master_port: single-access APB engine.
  - Inputs: start, addr, wdata, write.
  - Outputs: done pulse, rdata.
  - The sequencer FSM issues one access per state.

Test Plan:
- After reset release, with a PREADY=1 slave model -> first two accesses are write 0x00=0x0063 then write 0x04=0x80; req_ready rises after the second completes.
- Write req dev=0x48 reg=0x01 wdata=0xA5 against the real apb_i2c with an ACKing I2C slave model -> TX writes 0x90, 0x01, 0xA5; CMD writes 0x90, 0x11, 0x51, final 0x01; rsp_err=0, rsp_rdata=0.
- Read req dev=0x48 reg=0x00, slave returns 0x3C -> SDA shows repeated START with addr byte 0x91; rsp_rdata=0x3C, rsp_err=0, STOP seen on bus.
- Slave NACKs the address byte -> exactly one CMD 0x41 write, STOP on bus, rsp_err=1, no RX read.
- STATUS model never sets IF, POLL_MAX=4 -> 4 STATUS reads, then CMD 0x41, rsp_err=3.
- STATUS returns AL=1 on s1 -> CMD 0x01 only, no STO; rsp_err=2.
- HRESET asserted mid-POLL -> PSEL/PENABLE drop to 0 asynchronously; on release, init writes repeat.
